// File: rtl/arm_pkg.sv
// Shared decode constants for the ARM pipeline: instruction modes, data-processing
// opcodes, ALU commands, condition codes and the condition evaluator.
package arm_pkg;

  // Instruction class, taken from instIn[27:26]
  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_NOP = 2'b11;

  // Data-processing opcodes, instIn[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // ALU commands consumed by the EXE stage
  localparam logic [3:0] EXE_NONE = 4'b0000;
  localparam logic [3:0] EXE_MOV  = 4'b0001;
  localparam logic [3:0] EXE_ADD  = 4'b0010;
  localparam logic [3:0] EXE_ADC  = 4'b0011;
  localparam logic [3:0] EXE_SUB  = 4'b0100;
  localparam logic [3:0] EXE_SBC  = 4'b0101;
  localparam logic [3:0] EXE_AND  = 4'b0110;
  localparam logic [3:0] EXE_ORR  = 4'b0111;
  localparam logic [3:0] EXE_EOR  = 4'b1000;
  localparam logic [3:0] EXE_MVN  = 4'b1001;

  // Condition field, instIn[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // True when the instruction's condition holds for flags {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file R0-R14. Two combinational read ports, one write port
// from WB. Address 15 reads the current PC+4; writes to 15 are dropped. A read of
// the register WB is writing this cycle returns the incoming value.
module register_file
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcIn,
  input  logic [3:0]  rdAddr1,
  input  logic [3:0]  rdAddr2,
  input  logic        wbEn,
  input  logic [3:0]  wbDest,
  input  logic [31:0] wbValue,
  output logic [31:0] rdData1,
  output logic [31:0] rdData2
);

  logic [31:0] regs [0:14];

  // Reset loads Ri <= i and wins over a simultaneous WB write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= 32'(i);
      end
    end else if (wbEn && (wbDest != 4'd15)) begin
      regs[wbDest] <= wbValue;
    end
  end

  // Read ports: PC for R15, write-through for a same-cycle WB hit, else the array
  always_comb begin
    rdData1 = 32'd0;
    rdData2 = 32'd0;
    if (rdAddr1 == 4'd15) begin
      rdData1 = pcIn;
    end else if (wbEn && (wbDest == rdAddr1)) begin
      rdData1 = wbValue;
    end else begin
      rdData1 = regs[rdAddr1];
    end
    if (rdAddr2 == 4'd15) begin
      rdData2 = pcIn;
    end else if (wbEn && (wbDest == rdAddr2)) begin
      rdData2 = wbValue;
    end else begin
      rdData2 = regs[rdAddr2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: control decode, condition/hazard gating, operand
// fields and register reads. Everything here is combinational except the register
// file writes, so the ID stage register sees a bubble whenever controls are gated.
module id_stage
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcIn,
  input  logic [31:0] instIn,
  input  logic [3:0]  status,
  input  logic        hazard,
  input  logic        wbWbEn,
  input  logic [3:0]  wbDest,
  input  logic [31:0] wbValue,
  output logic        writeBackEn,
  output logic        memReadEn,
  output logic        memWriteEn,
  output logic        b,
  output logic        s,
  output logic [3:0]  exeCmd,
  output logic [31:0] pc,
  output logic [31:0] valRn,
  output logic [31:0] valRm,
  output logic        imm,
  output logic [11:0] shiftOperand,
  output logic [23:0] signedImm24,
  output logic [3:0]  dest,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        twoSrc
);

  logic [3:0] cond;
  logic [1:0] mode;
  logic [3:0] opcode;
  logic       sBit;
  logic       isStore;
  logic       condOk;
  logic       issue;

  logic rawWbEn, rawMemRead, rawMemWrite, rawB, rawS;

  assign cond   = instIn[31:28];
  assign mode   = instIn[27:26];
  assign opcode = instIn[24:21];
  assign sBit   = instIn[20];

  assign pc           = pcIn;
  assign imm          = instIn[25];
  assign shiftOperand = instIn[11:0];
  assign signedImm24  = instIn[23:0];
  assign dest         = instIn[15:12];

  // Source numbers feed the hazard unit, so they come from the raw decode
  assign isStore = (mode == MODE_MEM) && !sBit;
  assign src1    = instIn[19:16];
  assign src2    = isStore ? instIn[15:12] : instIn[3:0];
  assign twoSrc  = ~imm | isStore;

  // Raw control decode by instruction class and opcode
  always_comb begin
    rawWbEn     = 1'b0;
    rawMemRead  = 1'b0;
    rawMemWrite = 1'b0;
    rawB        = 1'b0;
    rawS        = 1'b0;
    exeCmd      = EXE_NONE;
    case (mode)
      MODE_DP: begin
        rawS    = sBit;
        rawWbEn = 1'b1;
        case (opcode)
          OP_MOV:  exeCmd = EXE_MOV;
          OP_MVN:  exeCmd = EXE_MVN;
          OP_ADD:  exeCmd = EXE_ADD;
          OP_ADC:  exeCmd = EXE_ADC;
          OP_SUB:  exeCmd = EXE_SUB;
          OP_SBC:  exeCmd = EXE_SBC;
          OP_AND:  exeCmd = EXE_AND;
          OP_ORR:  exeCmd = EXE_ORR;
          OP_EOR:  exeCmd = EXE_EOR;
          OP_CMP: begin
            exeCmd  = EXE_SUB;
            rawWbEn = 1'b0;
          end
          OP_TST: begin
            exeCmd  = EXE_AND;
            rawWbEn = 1'b0;
          end
          default: begin
            exeCmd  = EXE_NONE;
            rawWbEn = 1'b0;
          end
        endcase
      end
      MODE_MEM: begin
        exeCmd = EXE_ADD;
        if (sBit) begin
          rawMemRead = 1'b1;
          rawWbEn    = 1'b1;
        end else begin
          rawMemWrite = 1'b1;
        end
      end
      MODE_BR: begin
        rawB = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // A failed condition or a stall turns the instruction into a bubble
  assign condOk = cond_pass(cond, status);
  assign issue  = condOk & ~hazard;

  assign writeBackEn = rawWbEn     & issue;
  assign memReadEn   = rawMemRead  & issue;
  assign memWriteEn  = rawMemWrite & issue;
  assign b           = rawB        & issue;
  assign s           = rawS        & issue;

  register_file u_regFile (
    .clk     (clk),
    .rst     (rst),
    .pcIn    (pcIn),
    .rdAddr1 (src1),
    .rdAddr2 (src2),
    .wbEn    (wbWbEn),
    .wbDest  (wbDest),
    .wbValue (wbValue),
    .rdData1 (valRn),
    .rdData2 (valRm)
  );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, condition gating, hazard, register file
// write-through, reset values and the R15 read path.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pcIn;
  logic [31:0] instIn;
  logic [3:0]  status;
  logic        hazard;
  logic        wbWbEn;
  logic [3:0]  wbDest;
  logic [31:0] wbValue;
  logic        writeBackEn, memReadEn, memWriteEn, b, s;
  logic [3:0]  exeCmd;
  logic [31:0] pc, valRn, valRm;
  logic        imm;
  logic [11:0] shiftOperand;
  logic [23:0] signedImm24;
  logic [3:0]  dest, src1, src2;
  logic        twoSrc;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .pcIn         (pcIn),
    .instIn       (instIn),
    .status       (status),
    .hazard       (hazard),
    .wbWbEn       (wbWbEn),
    .wbDest       (wbDest),
    .wbValue      (wbValue),
    .writeBackEn  (writeBackEn),
    .memReadEn    (memReadEn),
    .memWriteEn   (memWriteEn),
    .b            (b),
    .s            (s),
    .exeCmd       (exeCmd),
    .pc           (pc),
    .valRn        (valRn),
    .valRm        (valRm),
    .imm          (imm),
    .shiftOperand (shiftOperand),
    .signedImm24  (signedImm24),
    .dest         (dest),
    .src1         (src1),
    .src2         (src2),
    .twoSrc       (twoSrc)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a new instruction mid-cycle and let the combinational outputs settle
  task automatic drive_inst(input logic [31:0] inst, input logic [3:0] flags, input logic hz);
    @(negedge clk);
    instIn = inst;
    status = flags;
    hazard = hz;
    #1;
  endtask

  task automatic drive_wb(input logic en, input logic [3:0] d, input logic [31:0] v);
    wbWbEn  = en;
    wbDest  = d;
    wbValue = v;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    pcIn     = 32'h0000_1000;
    instIn   = 32'hEC00_0000;
    status   = 4'b0000;
    hazard   = 1'b0;
    wbWbEn   = 1'b0;
    wbDest   = 4'd0;
    wbValue  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ADD R1,R2,R3 straight after reset
    drive_inst(32'hE082_1003, 4'b0000, 1'b0);
    chk("add_valRn", valRn, 32'd2);
    chk("add_valRm", valRm, 32'd3);
    chk("add_exeCmd", {28'd0, exeCmd}, 32'h2);
    chk("add_wbEn", {31'd0, writeBackEn}, 32'd1);
    chk("add_dest", {28'd0, dest}, 32'd1);
    chk("add_src1", {28'd0, src1}, 32'd2);
    chk("add_src2", {28'd0, src2}, 32'd3);
    chk("add_twoSrc", {31'd0, twoSrc}, 32'd1);
    chk("add_pc", pc, 32'h0000_1000);

    // Same-cycle write-through, then committed value
    drive_wb(1'b1, 4'd2, 32'h55);
    chk("wt_valRn", valRn, 32'h55);
    chk("wt_valRm_untouched", valRm, 32'd3);
    @(negedge clk);
    drive_wb(1'b0, 4'd0, 32'd0);
    chk("commit_valRn", valRn, 32'h55);

    // ADDEQ: Z clear gates everything, Z set lets it through
    drive_inst(32'h0082_1003, 4'b0000, 1'b0);
    chk("addeq_fail_wbEn", {31'd0, writeBackEn}, 32'd0);
    chk("addeq_fail_exeCmd", {28'd0, exeCmd}, 32'h2);
    drive_inst(32'h0082_1003, 4'b0100, 1'b0);
    chk("addeq_pass_wbEn", {31'd0, writeBackEn}, 32'd1);

    // STR R1,[R2], then stalled
    drive_inst(32'hE582_1000, 4'b0000, 1'b0);
    chk("str_memWr", {31'd0, memWriteEn}, 32'd1);
    chk("str_wbEn", {31'd0, writeBackEn}, 32'd0);
    chk("str_exeCmd", {28'd0, exeCmd}, 32'h2);
    chk("str_src2", {28'd0, src2}, 32'd1);
    chk("str_twoSrc", {31'd0, twoSrc}, 32'd1);
    chk("str_valRm", valRm, 32'd1);
    drive_inst(32'hE582_1000, 4'b0000, 1'b1);
    chk("str_hz_memWr", {31'd0, memWriteEn}, 32'd0);
    chk("str_hz_src2", {28'd0, src2}, 32'd1);

    // LDR R1,[R2]
    drive_inst(32'hE592_1000, 4'b0000, 1'b0);
    chk("ldr_memRd", {31'd0, memReadEn}, 32'd1);
    chk("ldr_wbEn", {31'd0, writeBackEn}, 32'd1);
    chk("ldr_memWr", {31'd0, memWriteEn}, 32'd0);
    chk("ldr_s", {31'd0, s}, 32'd0);
    chk("ldr_src2", {28'd0, src2}, 32'd0);

    // Branch and CMP
    drive_inst(32'hEA00_0004, 4'b0000, 1'b0);
    chk("b_b", {31'd0, b}, 32'd1);
    chk("b_imm24", {8'd0, signedImm24}, 32'h4);
    chk("b_wbEn", {31'd0, writeBackEn}, 32'd0);
    drive_inst(32'hE152_0003, 4'b0000, 1'b0);
    chk("cmp_wbEn", {31'd0, writeBackEn}, 32'd0);
    chk("cmp_s", {31'd0, s}, 32'd1);
    chk("cmp_exeCmd", {28'd0, exeCmd}, 32'h4);

    // MVN R1,#5: immediate form has one source
    drive_inst(32'hE3E0_1005, 4'b0000, 1'b0);
    chk("mvn_exeCmd", {28'd0, exeCmd}, 32'h9);
    chk("mvn_imm", {31'd0, imm}, 32'd1);
    chk("mvn_twoSrc", {31'd0, twoSrc}, 32'd0);
    chk("mvn_shiftOp", {20'd0, shiftOperand}, 32'h005);

    // No-op class and never-condition
    drive_inst(32'hEC00_0000, 4'b0000, 1'b0);
    chk("nop_ctrl", {27'd0, writeBackEn, memReadEn, memWriteEn, b, s}, 32'd0);
    chk("nop_exeCmd", {28'd0, exeCmd}, 32'h0);
    drive_inst(32'hF082_1003, 4'b0000, 1'b0);
    chk("nv_wbEn", {31'd0, writeBackEn}, 32'd0);

    // GT, LS and unused opcode
    drive_inst(32'hC082_1003, 4'b0000, 1'b0);
    chk("gt_pass", {31'd0, writeBackEn}, 32'd1);
    drive_inst(32'hC082_1003, 4'b1000, 1'b0);
    chk("gt_fail", {31'd0, writeBackEn}, 32'd0);
    drive_inst(32'h9082_1003, 4'b0010, 1'b0);
    chk("ls_fail", {31'd0, writeBackEn}, 32'd0);
    drive_inst(32'h9082_1003, 4'b0110, 1'b0);
    chk("ls_pass", {31'd0, writeBackEn}, 32'd1);
    drive_inst(32'hE060_1003, 4'b0000, 1'b0);
    chk("badop_exeCmd", {28'd0, exeCmd}, 32'h0);
    chk("badop_wbEn", {31'd0, writeBackEn}, 32'd0);

    // R5 <= 0xAA, then reset (with a competing WB write) restores 5
    drive_inst(32'hE085_0003, 4'b0000, 1'b0);
    drive_wb(1'b1, 4'd5, 32'hAA);
    @(negedge clk);
    drive_wb(1'b0, 4'd0, 32'd0);
    chk("r5_written", valRn, 32'hAA);
    rst = 1'b1;
    drive_wb(1'b1, 4'd5, 32'h77);
    @(negedge clk);
    rst = 1'b0;
    drive_wb(1'b0, 4'd0, 32'd0);
    chk("r5_after_rst", valRn, 32'd5);

    // All registers back to their index after reset
    for (int i = 0; i < 15; i++) begin
      drive_inst(32'hE080_0000 | (32'(i) << 16) | 32'(14 - i), 4'b0000, 1'b0);
      exp_q.push_back(32'(i));
      exp_q.push_back(32'(14 - i));
      chk("sweep_valRn", valRn, exp_q.pop_front());
      chk("sweep_valRm", valRm, exp_q.pop_front());
    end

    // R15: write is dropped and reads return pcIn, also during the write cycle
    pcIn = 32'h0000_1234;
    drive_inst(32'hE08F_000F, 4'b0000, 1'b0);
    drive_wb(1'b1, 4'd15, 32'h99);
    chk("r15_during_wr", valRn, 32'h0000_1234);
    chk("r15_rm_during_wr", valRm, 32'h0000_1234);
    @(negedge clk);
    drive_wb(1'b0, 4'd0, 32'd0);
    pcIn = 32'h0000_5678;
    #1;
    chk("r15_after_wr", valRn, 32'h0000_5678);
    chk("r15_pc_pass", pc, 32'h0000_5678);

    do_reset();
    drive_inst(32'hE082_1003, 4'b0000, 1'b0);
    chk("final_valRn", valRn, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage ARM pipeline. It sits between the IF stage register and the ID stage register. It decodes the fetched instruction into control signals and operand fields, and reads Rn/Rm from the architectural register file. The register file lives here and is written by the WB stage. Condition evaluation against the status flags and the hazard stall are also applied here, so the ID stage register latches a bubble whenever the instruction must not take effect.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- pcIn  in  32  PC+4 of the instruction, from the IF stage register
- instIn  in  32  instruction word
- status  in  4  NZCV flags {N,Z,C,V} from the EXE status register
- hazard  in  1  stall request from the hazard unit
- wbWbEn  in  1  WB-stage register write enable
- wbDest  in  4  WB-stage destination register
- wbValue  in  32  WB-stage write data
- writeBackEn, memReadEn, memWriteEn, b, s  out  1 each  gated control signals
- exeCmd  out  4  ALU command
- pc  out  32  pass-through of pcIn
- valRn, valRm  out  32  register operands
- imm  out  1  instIn[25]
- shiftOperand  out  12  instIn[11:0]
- signedImm24  out  24  instIn[23:0]
- dest  out  4  instIn[15:12]
- src1, src2  out  4  source register numbers for the hazard unit
- twoSrc  out  1  instruction reads a second register

## Operation
- Mode is instIn[27:26]: 00 = data-processing, 01 = memory, 10 = branch, 11 = no-op (all controls 0).
- Data-processing opcode instIn[24:21] maps to exeCmd as follows:
  - MOV 1101→0001, MVN 1111→1001
  - ADD 0100→0010, ADC 0101→0011
  - SUB 0010→0100, SBC 0110→0101
  - AND 0000→0110, ORR 1100→0111, EOR 0001→1000
  - CMP 1010→0100, TST 1000→0110
  - Any other opcode → exeCmd 0000, writeBackEn 0.
- Data-processing write-back: writeBackEn=1 except for CMP and TST. s=instIn[20].
- Memory: exeCmd=0010. instIn[20]=1 is LDR (memReadEn=1, writeBackEn=1); otherwise STR (memWriteEn=1). s=0 for both.
- Branch: b=1, exeCmd=0000 (don't-care).
- Condition field instIn[31:28] follows the standard ARM table:
  - EQ/NE test Z; CS/CC test C; MI/PL test N; VS/VC test V
  - HI = C&~Z; LS = ~C|Z
  - GE = N==V; LT = N!=V
  - GT = ~Z&(N==V); LE = Z|(N!=V)
  - AL = 1; 1111 = 0
- Gating: if the condition fails or hazard=1, force writeBackEn, memReadEn, memWriteEn, b and s to 0. All other outputs are unaffected.
- Source registers: src1=instIn[19:16]. src2=instIn[15:12] when memory-store (mode 01, L=0), else instIn[3:0]. src1/src2 are computed from the raw decode, ungated.
- twoSrc = ~imm | store. This is raw decode, ungated.
- Register file: 15×32 registers, R0–R14.
  - Read address 15 returns pcIn.
  - Write to address 15 is ignored.
- Write-through: if wbWbEn and wbDest==read address (≠15), the read returns wbValue in the same cycle.

## Timing
- Decode, condition check, register reads and all outputs are combinational from the inputs, with zero latency. Outputs are consumed by the ID stage register on the next edge.
- Register write commits on the rising edge where wbWbEn=1 and rst=0. The new value is visible combinationally from then on, and via write-through during the write cycle itself.
- Reset, on the rising edge with rst=1: register Ri ← i (i = 0..14). The reset overrides a simultaneous WB write.
- Outputs have no reset value of their own; during reset they reflect the current inputs.

## Structure
- Package arm_pkg holds:
  - mode, opcode and exeCmd localparams
  - condition-code constants
  - a pure function cond_pass(cond, nzcv)
- Sub-module register_file holds the 15×32 array, synchronous write, synchronous reset and write-through. id_stage keeps only the control decode and the gating.

## Test plan
- Reset, then instIn=0xE0821003 (ADD R1,R2,R3), hazard=0 → valRn=2, valRm=3, exeCmd=0010, writeBackEn=1, dest=1, src1=2, src2=3, twoSrc=1.
- Same cycle as that ADD, drive wbWbEn=1, wbDest=2, wbValue=0x55 → valRn=0x55 immediately. Next cycle, with wbWbEn=0 → valRn still 0x55.
- instIn=0x00821003 (ADDEQ) with status=0000 → all gated controls 0, exeCmd still 0010. With status=0100 → writeBackEn=1.
- instIn=0xE5821000 (STR R1,[R2]) → memWriteEn=1, writeBackEn=0, exeCmd=0010, src2=1, twoSrc=1. Raising hazard → memWriteEn=0 while src2 is unchanged.
- instIn=0xEA000004 (B) → b=1, signedImm24=0x000004. instIn=0xE1520003 (CMP R2,R3) → writeBackEn=0, s=1, exeCmd=0100.
- Write R5=0xAA, then assert rst → R5 reads 5. Write with wbDest=15 → reading R15 returns pcIn.
